// File: rtl/sobel_black_border.sv
// -----------------------------------------------------------------------------
// sobel_black_border
// Computes one Sobel edge-magnitude pixel from the eight neighbours of a 3x3
// greyscale window. Single-shot: a low reset arms it, it walks
// LOAD -> GRAD -> ABS -> MAG -> DONE, presents the result and then holds it
// until the next reset. Pixels on the image border are forced to black.
//
// Ports
//   clk            in   1   pixel clock, rising-edge active
//   reset          in   1   synchronous, active-low; aborts and re-arms
//   row            in  10   line index of the centre pixel
//   col            in  10   pixel index of the centre pixel
//   inputPixels    in  64   {NW,N,NE,W,E,SW,S,SE}, 8b unsigned each
//   out            out  8   edge magnitude (0 while no valid result)
//   sobelFinished  out  1   high while out holds a valid result
// -----------------------------------------------------------------------------
module sobel_black_border #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    input  logic [63:0] inputPixels,
    output logic [7:0]  out,
    output logic        sobelFinished
);

    localparam logic [9:0] ROW_LAST = 10'(V_LINES - 1);
    localparam logic [9:0] COL_LAST = 10'(H_PIXELS - 1);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_GRAD = 3'd1,
        S_ABS  = 3'd2,
        S_MAG  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    logic [63:0]        r_pix;
    logic               r_border;
    logic signed [10:0] r_gx;
    logic signed [10:0] r_gy;
    logic [9:0]         r_ax;
    logic [9:0]         r_ay;
    logic [7:0]         r_out;
    logic               r_finished;

    // Neighbour taps from the registered window
    logic [7:0] w_nw, w_n, w_ne, w_w, w_e, w_sw, w_s, w_se;
    assign {w_nw, w_n, w_ne, w_w, w_e, w_sw, w_s, w_se} = r_pix;

    // Weighted column/row sums; each is at most 4*255 = 1020 so fits 10 bits
    logic [9:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    assign w_gx_pos = {2'b00, w_ne} + {1'b0, w_e, 1'b0} + {2'b00, w_se};
    assign w_gx_neg = {2'b00, w_nw} + {1'b0, w_w, 1'b0} + {2'b00, w_sw};
    assign w_gy_pos = {2'b00, w_sw} + {1'b0, w_s, 1'b0} + {2'b00, w_se};
    assign w_gy_neg = {2'b00, w_nw} + {1'b0, w_n, 1'b0} + {2'b00, w_ne};

    logic signed [10:0] w_gx, w_gy;
    assign w_gx = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
    assign w_gy = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});

    // Window position test for the black border
    logic w_border;
    assign w_border = (row == 10'd0) || (row >= ROW_LAST) ||
                      (col == 10'd0) || (col >= COL_LAST);

    // Magnitudes: |-1020| still fits in 10 bits, so the truncation is lossless
    logic [10:0] w_ax_full, w_ay_full;
    logic [10:0] w_sum;
    logic [7:0]  w_sat;

    // Absolute value and saturating sum
    always_comb begin
        w_ax_full = 11'd0;
        w_ay_full = 11'd0;
        w_sum     = 11'd0;
        w_sat     = 8'd0;
        if (r_gx[10]) begin
            w_ax_full = 11'(-r_gx);
        end else begin
            w_ax_full = 11'(r_gx);
        end
        if (r_gy[10]) begin
            w_ay_full = 11'(-r_gy);
        end else begin
            w_ay_full = 11'(r_gy);
        end
        w_sum = {1'b0, r_ax} + {1'b0, r_ay};
        if (w_sum > 11'd255) begin
            w_sat = 8'd255;
        end else begin
            w_sat = w_sum[7:0];
        end
    end

    // Control FSM and datapath registers; outputs are registered here
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_LOAD;
            r_pix      <= 64'd0;
            r_border   <= 1'b0;
            r_gx       <= 11'sd0;
            r_gy       <= 11'sd0;
            r_ax       <= 10'd0;
            r_ay       <= 10'd0;
            r_out      <= 8'd0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_pix    <= inputPixels;
                    r_border <= w_border;
                    r_state  <= S_GRAD;
                end
                S_GRAD: begin
                    r_gx    <= w_gx;
                    r_gy    <= w_gy;
                    r_state <= S_ABS;
                end
                S_ABS: begin
                    r_ax    <= w_ax_full[9:0];
                    r_ay    <= w_ay_full[9:0];
                    r_state <= S_MAG;
                end
                S_MAG: begin
                    r_out      <= r_border ? 8'd0 : w_sat;
                    r_finished <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    // Unreachable encodings fall back to a safe, unflagged state
                    r_state    <= S_LOAD;
                    r_out      <= 8'd0;
                    r_finished <= 1'b0;
                end
            endcase
        end
    end

    assign out           = r_out;
    assign sobelFinished = r_finished;

endmodule

// File: tb/tb_sobel_black_border.sv
module tb_sobel_black_border;

    logic        clk;
    logic        reset;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [63:0] inputPixels;
    logic [7:0]  out;
    logic        sobelFinished;

    int n_tests;
    int n_fail;

    sobel_black_border #(.H_PIXELS(640), .V_LINES(480)) dut (
        .clk           (clk),
        .reset         (reset),
        .row           (row),
        .col           (col),
        .inputPixels   (inputPixels),
        .out           (out),
        .sobelFinished (sobelFinished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [63:0] pix;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [63:0] pack(input logic [7:0] nw, input logic [7:0] n,
                                         input logic [7:0] ne, input logic [7:0] w,
                                         input logic [7:0] e,  input logic [7:0] sw,
                                         input logic [7:0] s,  input logic [7:0] se);
        return {nw, n, ne, w, e, sw, s, se};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reset for one edge, present inputs, release reset.
    task automatic arm(input logic [9:0] r, input logic [9:0] c, input logic [63:0] p);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_finished", int'(sobelFinished), 0);
        check("reset_out", int'(out), 0);
        @(negedge clk);
        row = r;
        col = c;
        inputPixels = p;
        reset = 1'b1;
    endtask

    // Full single-shot run; inputs are scrambled after the LOAD edge so a
    // late sample would be visible (row 0 would force the result to black).
    task automatic run_vec(input vec_t v);
        arm(v.row, v.col, v.pix);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                check({v.name, "_busy_finished"}, int'(sobelFinished), 0);
                check({v.name, "_busy_out"}, int'(out), 0);
                if (k == 1) begin
                    row = 10'd0;
                    col = 10'd0;
                    inputPixels = {$urandom, $urandom};
                end
            end else begin
                check({v.name, "_finished"}, int'(sobelFinished), 1);
                check({v.name, "_out"}, int'(out), int'(v.exp_out));
            end
        end
    endtask

    initial begin
        logic [63:0] p_flat, p_vert, p_weak;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        row = 10'd0;
        col = 10'd0;
        inputPixels = 64'd0;

        p_flat = pack(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        p_vert = pack(8'd0, 8'd128, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128, 8'd255);
        p_weak = pack(8'd0, 8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10);

        // Expected values hand-computed from Gx/Gy definitions
        vecs[0]  = '{"flat",       10'd10,  10'd10,  p_flat, 8'd0};
        vecs[1]  = '{"vert_sat",   10'd10,  10'd10,  p_vert, 8'd255};
        vecs[2]  = '{"weak",       10'd5,   10'd5,   p_weak, 8'd40};
        vecs[3]  = '{"brd_row0",   10'd0,   10'd10,  p_vert, 8'd0};
        vecs[4]  = '{"brd_col639", 10'd10,  10'd639, p_vert, 8'd0};
        vecs[5]  = '{"brd_row479", 10'd479, 10'd10,  p_vert, 8'd0};
        vecs[6]  = '{"brd_col0",   10'd10,  10'd0,   p_vert, 8'd0};
        vecs[7]  = '{"inner_max",  10'd478, 10'd638, p_weak, 8'd40};
        // Gx = -40, Gy = 0
        vecs[8]  = '{"neg_gx",     10'd1,   10'd1,
                     pack(8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd0), 8'd40};
        // Gx = -200, Gy = -200 -> 400 saturates
        vecs[9]  = '{"nw_sat",     10'd20,  10'd30,
                     pack(8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 8'd255};
        // Gx = 0, Gy = -100
        vecs[10] = '{"north",      10'd20,  10'd30,
                     pack(8'd0, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 8'd100};
        // Gx = 30, Gy = 30
        vecs[11] = '{"se_only",    10'd20,  10'd30,
                     pack(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30), 8'd60};

        repeat (2) @(posedge clk);
        #1;
        check("init_finished", int'(sobelFinished), 0);
        check("init_out", int'(out), 0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Abort after two computation edges, then rerun with the weak edge
        arm(10'd10, 10'd10, p_vert);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_finished", int'(sobelFinished), 0);
        check("abort_out", int'(out), 0);
        @(negedge clk);
        row = 10'd5;
        col = 10'd5;
        inputPixels = p_weak;
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                check("rerun_busy", int'(sobelFinished), 0);
            end else begin
                check("rerun_finished", int'(sobelFinished), 1);
                check("rerun_out", int'(out), 40);
            end
        end

        // DONE holds regardless of input activity
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            row = 10'(k * 37);
            col = 10'(k * 53);
            inputPixels = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("hold_finished", int'(sobelFinished), 1);
            check("hold_out", int'(out), 40);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
